// File: rtl/dma_io_device.sv
`default_nettype none
// ============================================================================
// Module   : dma_io_device
// Purpose  : Peripheral-side endpoint of a DMA single-transfer handshake.
//            A local FIFO sits between the device logic and the DMA bus.
//            With dir=0 the device sources FIFO bytes onto the bus during
//            IOR_N cycles; with dir=1 it sinks bus bytes from IOW_N cycles
//            into the FIFO. EOP_N (terminal count) is latched in tcFlag
//            and halts further requests until software clears it.
// Ports    : CLK, Reset          clock / synchronous active-high reset
//            dir                 transfer direction, taken in IDLE only
//            DREQ / DACK         DMA request (registered) / acknowledge
//            IOR_N, IOW_N, EOP_N active-low bus strobes and terminal count
//            DB_in, DB_out, DB_oe data bus in / out / output enable
//            locData/Valid/Ready local push port (dir=0)
//            rdData/Valid/Ready  local pop port (dir=1)
//            tcFlag, tcClear     sticky terminal-count flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module dma_io_device #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              dir,
    output logic              DREQ,
    input  logic              DACK,
    input  logic              IOR_N,
    input  logic              IOW_N,
    input  logic              EOP_N,
    input  logic [DATA_W-1:0] DB_in,
    output logic [DATA_W-1:0] DB_out,
    output logic              DB_oe,
    input  logic [DATA_W-1:0] locData,
    input  logic              locValid,
    output logic              locReady,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    input  logic              rdReady,
    output logic              tcFlag,
    input  logic              tcClear
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        XFER    = 3'd2,
        RECOVER = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t              state;
    logic                dir_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                ior_low_q;
    logic                iow_low_q;
    logic [DATA_W-1:0]   db_latch;
    logic                tc_q;
    logic                dreq_q;

    logic                full;
    logic                empty;
    logic                mode;
    logic                in_xfer;
    logic                ior_edge;
    logic                iow_edge;
    logic                bus_pop;
    logic                bus_push;
    logic                loc_push;
    logic                loc_pop;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   push_data;
    logic [DATA_W-1:0]   head;
    logic                eop_hit;
    logic                want_xfer;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // In IDLE the live dir input is authoritative; once a request is under
    // way the direction captured in IDLE is held so a change of dir cannot
    // corrupt a transfer in flight.
    assign mode    = (state == IDLE) ? dir : dir_q;

    // Strobe rising edge: low (with DACK) on the previous clock, high now.
    // Only an edge seen in XFER moves data.
    assign in_xfer  = (state == XFER);
    assign ior_edge = in_xfer && ior_low_q && IOR_N;
    assign iow_edge = in_xfer && iow_low_q && IOW_N;

    // A bus write into a full FIFO is silently dropped.
    assign bus_pop  = !dir_q && ior_edge && !empty;
    assign bus_push =  dir_q && iow_edge && !full;

    // Local handshakes. A bus pop frees the slot the local push uses in the
    // same cycle, so a full FIFO can still accept. When bus and local side
    // want the same operation the bus wins and the local side is held off.
    assign locReady = !mode && (!full || bus_pop) && !bus_push;
    assign rdValid  =  mode && !empty && !bus_pop;
    assign rdData   = head;

    assign loc_push  = locValid && locReady;
    assign loc_pop   = rdValid && rdReady;
    assign push      = bus_push || loc_push;
    assign pop       = bus_pop || loc_pop;
    assign push_data = bus_push ? db_latch : locData;

    // Drive the bus only while acknowledged and being read.
    assign DB_oe  = ((state == REQ) || in_xfer) && DACK && !IOR_N && !dir_q;
    assign DB_out = DB_oe ? head : '0;

    assign eop_hit = DACK && !EOP_N &&
                     ((state == REQ) || in_xfer || (state == RECOVER));

    assign want_xfer = dir ? (count < FULL_CNT) : !empty;

    assign DREQ   = dreq_q;
    assign tcFlag = tc_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ior_low_q <= 1'b0;
            iow_low_q <= 1'b0;
            db_latch  <= '0;
            tc_q      <= 1'b0;
            dreq_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // ---------------- FIFO storage ----------------
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // ---------------- bus sampling ----------------
            // Strobes without DACK belong to another channel.
            ior_low_q <= DACK && !IOR_N;
            iow_low_q <= DACK && !IOW_N;
            if (DACK && !IOW_N) begin
                db_latch <= DB_in;
            end

            // Set has priority over a coincident clear.
            if (eop_hit) begin
                tc_q <= 1'b1;
            end else if (tcClear) begin
                tc_q <= 1'b0;
            end

            // ---------------- handshake FSM ----------------
            case (state)
                IDLE: begin
                    dir_q  <= dir;
                    dreq_q <= 1'b0;
                    if (want_xfer && !tc_q) begin
                        state  <= REQ;
                        dreq_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (DACK) begin
                        if (!EOP_N) begin
                            state  <= HALT;
                            dreq_q <= 1'b0;
                        end else begin
                            state  <= XFER;
                        end
                    end
                end
                XFER: begin
                    // A strobe edge coinciding with EOP still moves its byte
                    // (bus_pop/bus_push above); only the next state differs.
                    if (eop_hit) begin
                        state  <= HALT;
                        dreq_q <= 1'b0;
                    end else if (dir_q ? iow_edge : ior_edge) begin
                        state  <= RECOVER;
                        dreq_q <= 1'b0;
                    end else if (!DACK) begin
                        state  <= IDLE;
                        dreq_q <= 1'b0;
                    end
                end
                RECOVER: begin
                    // DREQ stays low here for one cycle so the controller
                    // sees each byte as a separate single transfer.
                    dreq_q <= 1'b0;
                    state  <= eop_hit ? HALT : IDLE;
                end
                HALT: begin
                    dreq_q <= 1'b0;
                    if (!tc_q) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    dreq_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
